load_store_unit: RTL

// Initiator side of the data-memory port. Takes one load/store request per transaction from
// the execute stage, drives the byte-addressed, little-endian data memory (combinational

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-wide data memory for byte/half/word accesses,
// using read-modify-write for sub-word stores and checking alignment and range.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request transfers on a clock edge where req_valid & req_ready are both
  // high; req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with no
  // backpressure.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] word_q;

  logic        accept;
  logic [2:0]  req_nbytes;
  logic [32:0] req_end;
  logic        req_err;
  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;
  logic [31:0] merge_data;

  assign accept = req_valid & req_ready;

  always_comb begin
    req_nbytes = 3'd4;
    case (req_size)
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
  end

  // 33-bit sum so addresses near the top of the space cannot wrap into range
  assign req_end = {1'b0, req_addr} + {30'd0, req_nbytes};
  assign req_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]))
                 | (req_end > 33'(MEM_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      word_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
      end
      if (state_q == S_RD) begin
        word_q <= mem_read_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = S_RESP;
          end else if (!req_write || (req_size != 2'b10)) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD:    state_d = write_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lane   = addr_q[1:0];
  assign byte_v = word_q[{lane, 3'b000} +: 8];
  assign half_v = word_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = word_q;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_v[7]}}, byte_v};
      2'b01:   load_ext = {{16{signed_q & half_v[15]}}, half_v};
      default: load_ext = word_q;
    endcase
  end

  always_comb begin
    merge_data = word_q;
    case (size_q)
      2'b00:   merge_data[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_data = wdata_q;
    endcase
  end

  // rst gates the write strobe and response so a reset mid-transaction leaves no trace
  always_comb begin
    req_ready        = (state_q == S_IDLE) & ~rst;
    resp_valid       = 1'b0;
    resp_rdata       = 32'd0;
    resp_err         = 1'b0;
    mem_address      = 32'd0;
    mem_write_data   = 32'd0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    case (state_q)
      S_RD: begin
        mem_read_enable = 1'b1;
        mem_address     = {addr_q[31:2], 2'b00};
      end
      S_WR: begin
        mem_write_enable = ~rst;
        mem_address      = {addr_q[31:2], 2'b00};
        mem_write_data   = merge_data;
      end
      S_RESP: begin
        resp_valid = ~rst;
        resp_err   = err_q & ~rst;
        resp_rdata = (err_q | write_q | rst) ? 32'd0 : load_ext;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule
